// File: rtl/spi_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared types and constants for the SPI responder block:
//                FSM encoding, SPI mode codes and default word width.
//  Revision    : 1.0  initial release
// ============================================================================
package spi_pkg;

  // Default number of bits per SPI word
  localparam int SPI_DATA_WIDTH = 8;

  // SPI mode codes, packed as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  // Frame state: IDLE between frames, ACTIVE while the synchronised cs_n is low
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

endpackage
`default_nettype wire

// File: rtl/spi_slave_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : spi_slave_if
//  Description : The four SPI pins between a master and this responder.
//  Revision    : 1.0  initial release
// ============================================================================
interface spi_slave_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;

  modport master (output sclk, output cs_n, output mosi, input miso);
  modport slave  (input sclk, input cs_n, input mosi, output miso);
endinterface
`default_nettype wire

// File: rtl/spi_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : spi_rx_fifo
//  Description : Synchronous first-word-fall-through FIFO for received words.
//                A push while full is accepted only if a pop happens in the
//                same cycle, so the occupancy stays at FIFO_DEPTH.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  empty,
  output logic                  full
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic                  do_rd;
  logic                  do_wr;

  // Pointers carry one extra wrap bit to tell full from empty
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
               (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
    do_rd    = read_en & ~empty;
    do_wr    = write_en & (~full | do_rd);
    wr_ptr_d = do_wr ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    read_data = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
  end

  // Pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= write_data;
  end

endmodule
`default_nettype wire

// File: rtl/spi_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : spi_slave
//  Description : SPI responder, all four CPOL/CPHA modes. Oversamples the
//                pins in the clk domain, deserialises MSB-first words into an
//                RX FIFO and serialises a TX holding register onto miso.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_DATA_WIDTH,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_slave_if.slave            spi,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  tx_wr_en,
  input  logic [DATA_WIDTH-1:0] tx_wr_data,
  output logic                  tx_ready,
  output logic                  busy,
  input  logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  rx_overrun,
  input  logic                  ovr_clr,
  output logic                  frame_err
);

  localparam int               CNT_W    = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_WORD = CNT_W'(DATA_WIDTH);

  // [0],[1] form the synchroniser, [2] is the previous value for edge detect
  logic [2:0]            sclk_sync_q, sclk_sync_d;
  logic [2:0]            cs_sync_q, cs_sync_d;
  logic [1:0]            mosi_sync_q, mosi_sync_d;
  spi_state_e            state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] tx_hold_q, tx_hold_d;
  logic                  tx_full_q, tx_full_d;
  logic                  reload_q, reload_d;
  logic                  miso_q, miso_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;

  logic                  sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic                  sample_edge, shift_edge, cs_fall, cs_rise;
  logic                  word_done, consume;
  logic [DATA_WIDTH-1:0] load_word;

  // Edge decode of the synchronised pins, mapped onto sample/shift edges per mode
  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], spi.sclk};
    cs_sync_d   = {cs_sync_q[1:0], spi.cs_n};
    mosi_sync_d = {mosi_sync_q[0], spi.mosi};
    sclk_rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
    sclk_fall   = ~sclk_sync_q[1] & sclk_sync_q[2];
    lead_edge   = cpol ? sclk_fall : sclk_rise;
    trail_edge  = cpol ? sclk_rise : sclk_fall;
    sample_edge = cpha ? trail_edge : lead_edge;
    shift_edge  = cpha ? lead_edge : trail_edge;
    cs_fall     = ~cs_sync_q[1] & cs_sync_q[2];
    cs_rise     = cs_sync_q[1] & ~cs_sync_q[2];
    word_done   = (bit_cnt_q == CNT_WORD);
    // An empty holding register sends zeros
    load_word   = tx_full_q ? tx_hold_q : '0;
  end

  // Frame FSM with RX/TX shifters; miso always mirrors the next bit to present
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    reload_d    = reload_q;
    miso_d      = miso_q;
    frame_err_d = 1'b0;
    consume     = 1'b0;

    // A completed word is pushed this cycle; the next shift edge starts a new TX word
    if (word_done) begin
      bit_cnt_d = '0;
      reload_d  = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        miso_d    = 1'b0;
        bit_cnt_d = '0;
        reload_d  = 1'b0;
        if (cs_fall) begin
          state_d    = ST_ACTIVE;
          tx_shift_d = load_word;
          consume    = 1'b1;
          // cpha=0 masters sample on the very first edge, so present the MSB now
          miso_d     = cpha ? 1'b0 : load_word[DATA_WIDTH-1];
        end
      end
      ST_ACTIVE: begin
        if (cs_rise) begin
          state_d     = ST_IDLE;
          bit_cnt_d   = '0;
          reload_d    = 1'b0;
          miso_d      = 1'b0;
          frame_err_d = (bit_cnt_q != '0) && !word_done;
        end else begin
          if (sample_edge) begin
            rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_sync_q[1]};
            bit_cnt_d  = bit_cnt_q + CNT_ONE;
          end
          if (shift_edge) begin
            if (reload_q) begin
              reload_d = 1'b0;
              consume  = 1'b1;
              miso_d   = load_word[DATA_WIDTH-1];
              tx_shift_d = cpha ? {load_word[DATA_WIDTH-2:0], 1'b0} : load_word;
            end else if (cpha) begin
              miso_d     = tx_shift_q[DATA_WIDTH-1];
              tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
            end else begin
              miso_d     = tx_shift_q[DATA_WIDTH-2];
              tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // TX holding register: a load is consumed first, a host write only lands when empty
  always_comb begin
    tx_hold_d = tx_hold_q;
    tx_full_d = consume ? 1'b0 : tx_full_q;
    if (tx_wr_en && !tx_full_q) begin
      tx_hold_d = tx_wr_data;
      tx_full_d = 1'b1;
    end
    // Set wins over clear; a push while full survives only with a concurrent pop
    overrun_d = (ovr_clr ? 1'b0 : overrun_q) | (word_done & fifo_full & ~fifo_rd_en);
  end

  // All block state, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      // Clearing cs_n history low means a cs_n already low at release is not a fall
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      tx_hold_q   <= '0;
      tx_full_q   <= 1'b0;
      reload_q    <= 1'b0;
      miso_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      tx_hold_q   <= tx_hold_d;
      tx_full_q   <= tx_full_d;
      reload_q    <= reload_d;
      miso_q      <= miso_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  spi_rx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_rx_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .write_en   (word_done),
    .write_data (rx_shift_q),
    .read_en    (fifo_rd_en),
    .read_data  (fifo_rd_data),
    .empty      (fifo_empty),
    .full       (fifo_full)
  );

  assign spi.miso   = miso_q;
  assign tx_ready   = ~tx_full_q;
  assign busy       = (state_q == ST_ACTIVE);
  assign rx_overrun = overrun_q;
  assign frame_err  = frame_err_q;

endmodule
`default_nettype wire
